// File: rtl/quad_pkg.sv
// Shared constants, state type and phase encoding for the quadrature generator.
package quad_pkg;

    localparam int POSW       = 14;
    localparam int MAXCNT_DEF = 9999;

    // (A,B) per phase index; a detent walks P1 -> P2 -> P3 -> P0.
    localparam logic [1:0] FWD_P1 = 2'b10;
    localparam logic [1:0] FWD_P2 = 2'b11;
    localparam logic [1:0] FWD_P3 = 2'b01;
    localparam logic [1:0] FWD_P0 = 2'b00;
    localparam logic [1:0] BWD_P1 = 2'b01;
    localparam logic [1:0] BWD_P2 = 2'b11;
    localparam logic [1:0] BWD_P3 = 2'b10;
    localparam logic [1:0] BWD_P0 = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    // A/B levels for a phase index in the given direction.
    function automatic logic [1:0] phase_ab(input logic fwd, input logic [1:0] ph);
        logic [1:0] ab;
        ab = 2'b00;
        case (ph)
            2'd1:    ab = fwd ? FWD_P1 : BWD_P1;
            2'd2:    ab = fwd ? FWD_P2 : BWD_P2;
            2'd3:    ab = fwd ? FWD_P3 : BWD_P3;
            default: ab = fwd ? FWD_P0 : BWD_P0;
        endcase
        return ab;
    endfunction

endpackage

// File: rtl/quad_tick.sv
// Phase-length prescaler: pulses tick on the last of every DIV cycles.
// While load is high the count is held at zero, so the first phase after
// load drops lasts exactly DIV cycles.
module quad_tick #(
    parameter int DIV = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int             TW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0]  LAST = TW'(DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    // Next count: restart on load, wrap after the last cycle of a phase.
    always_comb begin
        cnt_d = cnt_q + TW'(1);
        if (load || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = !load && (cnt_q == LAST);

endmodule

// File: rtl/quad_gen.sv
// Quadrature encoder emulator: converts a step command into an A/B Gray
// sequence, one full P1..P0 cycle per detent, and tracks a wrapping position.
module quad_gen
    import quad_pkg::*;
#(
    parameter int DIV    = 250,
    parameter int MAXCNT = MAXCNT_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            dir,
    input  logic [POSW-1:0] steps,
    input  logic            stop,
    output logic            qa,
    output logic            qb,
    output logic            busy,
    output logic            done,
    output logic [POSW-1:0] pos
);

    localparam logic [POSW-1:0] MAXV = POSW'(MAXCNT);

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic            dir_q, dir_d;
    logic [POSW-1:0] rem_q, rem_d;
    logic            stop_q, stop_d;
    logic [POSW-1:0] pos_q, pos_d;
    logic [1:0]      ab_q, ab_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;

    // Position after one detent, wrapping at both ends of 0..MAXCNT.
    function automatic logic [POSW-1:0] next_pos(input logic [POSW-1:0] p, input logic fwd);
        logic [POSW-1:0] r;
        if (fwd) begin
            r = (p >= MAXV) ? '0 : p + POSW'(1);
        end else begin
            r = (p == '0) ? MAXV : p - POSW'(1);
        end
        return r;
    endfunction

    quad_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (state_q != ST_RUN),
        .tick (tick)
    );

    // Command sequencing: phase stepping, detent accounting and stop handling.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        stop_d  = stop_q;
        pos_d   = pos_q;
        ab_d    = ab_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ab_d   = 2'b00;
                busy_d = 1'b0;
                stop_d = 1'b0;
                if (start) begin
                    dir_d = dir;
                    rem_d = steps;
                    if (steps != '0) begin
                        state_d = ST_RUN;
                        phase_d = 2'd1;
                        busy_d  = 1'b1;
                        ab_d    = phase_ab(dir, 2'd1);
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    stop_d = 1'b1;
                end
                if (tick) begin
                    if (phase_q == 2'd0) begin
                        // End of a detent: account for it, then finish or chain.
                        pos_d = next_pos(pos_q, dir_q);
                        rem_d = rem_q - POSW'(1);
                        if ((rem_q == POSW'(1)) || stop_q || stop) begin
                            state_d = ST_FIN;
                            busy_d  = 1'b0;
                            ab_d    = 2'b00;
                        end else begin
                            phase_d = 2'd1;
                            ab_d    = phase_ab(dir_q, 2'd1);
                        end
                    end else begin
                        phase_d = phase_q + 2'd1;
                        ab_d    = phase_ab(dir_q, phase_q + 2'd1);
                    end
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                stop_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            phase_q <= 2'd0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
            stop_q  <= 1'b0;
            pos_q   <= '0;
            ab_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
            stop_q  <= stop_d;
            pos_q   <= pos_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign qa   = ab_q[1];
    assign qb   = ab_q[0];
    assign busy = busy_q;
    assign done = done_q;
    assign pos  = pos_q;

endmodule

// File: tb/tb_quad_gen.sv
// Bench for quad_gen: directed scenarios plus randomized commands, all
// checked every cycle against a timeline model of the command in flight.
module tb_quad_gen;

    localparam int DIV  = 4;
    localparam int MAXC = 9999;
    localparam int M    = MAXC + 1;
    localparam int DET  = 4 * DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic        dir   = 1'b0;
    logic        stop  = 1'b0;
    logic [13:0] steps = 14'd0;
    logic        qa, qb, busy, done;
    logic [13:0] pos;

    int total = 0;
    int bad   = 0;

    quad_gen #(.DIV(DIV), .MAXCNT(MAXC)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .dir   (dir),
        .steps (steps),
        .stop  (stop),
        .qa    (qa),
        .qb    (qb),
        .busy  (busy),
        .done  (done),
        .pos   (pos)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // A command is a timeline starting at the edge that accepted it (t0):
    // n detents of DET cycles, then one cycle with busy low, then done.
    int cyc, t0, n, pos0, mk, nn;
    bit have_cmd, mdir;

    function automatic int wrap_pos(input int p, input bit fwd, input int d);
        return fwd ? (p + d) % M : (((p - d) % M) + M) % M;
    endfunction

    function automatic int final_pos();
        return have_cmd ? wrap_pos(pos0, mdir, n) : pos0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc = 0; t0 = 0; n = 0; pos0 = 0; have_cmd = 0; mdir = 0;
        end else begin
            cyc = cyc + 1;
            mk  = cyc - t0;
            // A stop seen while running limits the command to the detent in progress.
            if (have_cmd && stop && mk >= 1 && mk <= DET * n) begin
                nn = (mk - 1) / DET + 1;
                if (nn < n) n = nn;
            end
            if (start && (!have_cmd || mk >= DET * n + 2)) begin
                pos0     = final_pos();
                have_cmd = 1;
                t0       = cyc;
                n        = int'(steps);
                mdir     = dir;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int  ck, d, ph, e_pos;
    bit  e_busy, e_done, e_a, e_b, pv, pqa, pqb;

    always @(negedge clk) begin
        if (rst) begin
            pv = 0;
        end else begin
            ck = cyc - t0;
            e_busy = 0; e_done = 0; e_a = 0; e_b = 0;
            e_pos = final_pos();
            if (have_cmd) begin
                if (ck < DET * n) begin
                    e_busy = 1;
                    d  = ck / DET;
                    ph = (ck % DET) / DIV;
                    // leading channel high in the first half of the detent,
                    // lagging channel high in the middle half
                    if (mdir) begin
                        e_a = (ph < 2); e_b = (ph == 1 || ph == 2);
                    end else begin
                        e_b = (ph < 2); e_a = (ph == 1 || ph == 2);
                    end
                    e_pos = wrap_pos(pos0, mdir, d);
                end else if (ck == DET * n + 1) begin
                    e_done = 1;
                end
            end
            total++;
            if (qa !== e_a || qb !== e_b || busy !== e_busy || done !== e_done || int'(pos) != e_pos) begin
                bad++;
                $display("FAIL model cyc=%0d: got qa=%b qb=%b busy=%b done=%b pos=%0d, need qa=%b qb=%b busy=%b done=%b pos=%0d",
                         cyc, qa, qb, busy, done, pos, e_a, e_b, e_busy, e_done, e_pos);
            end
            if (pv) begin
                total++;
                if (qa !== pqa && qb !== pqb) begin
                    bad++;
                    $display("FAIL gray cyc=%0d: ab went %b%b -> %b%b, need at most one channel change",
                             cyc, pqa, pqb, qa, qb);
                end
            end
            pv = 1; pqa = qa; pqb = qb;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input bit dd, input int s);
        dir   = dd;
        steps = 14'(s);
        start = 1'b1;
        stop  = 1'b0;
        step();
        start = 1'b0;
        dir   = 1'($urandom_range(0, 1));
        steps = 14'($urandom_range(0, 16383));
    endtask

    task automatic wait_done(input int maxc, input bit noise, output int cyc_o, output int busy_o);
        bit seen;
        seen   = 0;
        cyc_o  = 0;
        busy_o = busy ? 1 : 0;
        for (int i = 0; i < maxc; i++) begin
            if (noise) begin
                stop  = ($urandom_range(0, 19) == 0);
                start = ($urandom_range(0, 14) == 0);
                dir   = 1'($urandom_range(0, 1));
                steps = 14'($urandom_range(0, 16383));
            end
            step();
            cyc_o++;
            if (busy) busy_o++;
            if (done) begin
                seen = 1;
                break;
            end
        end
        start = 1'b0;
        stop  = 1'b0;
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: no done within %0d cycles, need one", maxc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end

    int c, b;

    initial begin
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("reset_ab",   int'({qa, qb}), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pos",  int'(pos), 0);

        // 1: forward, three detents
        issue(1, 3);
        chk("t1_first_ab", int'({qa, qb}), 2);
        wait_done(200, 0, c, b);
        chk("t1_latency", c, 49);
        chk("t1_busy_len", b, 48);
        chk("t1_pos", int'(pos), 3);
        chk("t1_ab_end", int'({qa, qb}), 0);
        step();
        chk("t1_done_once", int'(done), 0);

        // 2: back to 0, then backward two detents across the wrap
        issue(0, 3);
        wait_done(200, 0, c, b);
        chk("t2_pos_zero", int'(pos), 0);
        step();
        issue(0, 2);
        repeat (DET) step();
        chk("t2_pos_mid", int'(pos), 9999);
        chk("t2_ab_mid", int'({qa, qb}), 1);
        wait_done(200, 0, c, b);
        chk("t2_pos", int'(pos), 9998);

        // 3: forward through MAXCNT to 0
        step();
        issue(1, 1);
        wait_done(200, 0, c, b);
        chk("t3_pos_max", int'(pos), 9999);
        step();
        issue(1, 1);
        wait_done(200, 0, c, b);
        chk("t3_latency", c, 17);
        chk("t3_pos_wrap", int'(pos), 0);

        // 4: zero-step command
        step();
        issue(1, 0);
        chk("t4_busy0", int'(busy), 0);
        chk("t4_done_early", int'(done), 0);
        step();
        chk("t4_done", int'(done), 1);
        chk("t4_ab", int'({qa, qb}), 0);
        chk("t4_pos", int'(pos), 0);
        step();

        // 5: stop inside detent 2 plus a start while busy
        issue(1, 10);
        repeat (DET + 4) step();
        stop  = 1'b1;
        start = 1'b1;
        dir   = 1'b0;
        steps = 14'd5;
        step();
        stop  = 1'b0;
        start = 1'b0;
        wait_done(DET * 12, 0, c, b);
        chk("t5_pos", int'(pos), 2);
        chk("t5_ab", int'({qa, qb}), 0);
        step();
        chk("t5_idle", int'(busy), 0);

        // 6: asynchronous reset in the middle of P2
        issue(1, 2);
        repeat (DET + 5) step();
        chk("t6_pre_ab", int'({qa, qb}), 3);
        chk("t6_pre_pos", int'(pos), 3);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_ab", int'({qa, qb}), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_pos", int'(pos), 0);
        step();
        step();
        rst = 1'b0;
        step();
        issue(0, 1);
        wait_done(200, 0, c, b);
        chk("t6_after_pos", int'(pos), 9999);

        // randomized commands with stop/start noise while running
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) step();
            issue(1'($urandom_range(0, 1)), $urandom_range(0, 4));
            wait_done(DET * 5 + 10, 1, c, b);
        end
        repeat (4) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
